// File: rtl/addr_xbar_pipe.sv
// addr_xbar_pipe: registered N-lane address crossbar for port sets A and B.
// Each bank takes its address from an explicitly selected source lane, or, in
// rotate mode, from lane (bank + rot_cnt) mod N. The routed beat is held in a
// single output register under valid/ready flow control.
// Optional macro XBAR_PERM_CHECK_EN builds the sticky duplicate-select checker
// that drives perm_err; without it perm_err is tied low and err_clr is unused.
module addr_xbar_pipe #(
  parameter int unsigned N   = 8,
  parameter int unsigned ADW = 5,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*ADW-1:0] addr_a_in,
  input  logic [N*ADW-1:0] addr_b_in,
  input  logic [N*IW-1:0]  sel_a,
  input  logic [N*IW-1:0]  sel_b,
  input  logic            mode,
  input  logic            rot_clr,
  input  logic            err_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*ADW-1:0] addr_a_out,
  output logic [N*ADW-1:0] addr_b_out,
  output logic [IW-1:0]    rot_cnt,
  output logic            perm_err
);

  logic              out_valid_q, out_valid_d;
  logic [N*ADW-1:0]  addr_a_q, addr_a_d;
  logic [N*ADW-1:0]  addr_b_q, addr_b_d;
  logic [IW-1:0]     rot_cnt_q, rot_cnt_d;
  logic [N*ADW-1:0]  route_a_c, route_b_c;
  logic [IW-1:0]     src_a, src_b;
  logic              accept_c;

  // The output slot frees up when it is empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_c = in_valid && in_ready;

  // Per-bank source lane selection; rotate mode uses the pre-increment offset.
  always_comb begin
    route_a_c = '0;
    route_b_c = '0;
    src_a     = '0;
    src_b     = '0;
    for (int j = 0; j < N; j++) begin
      if (mode) begin
        src_a = IW'(j) + rot_cnt_q;
        src_b = IW'(j) + rot_cnt_q;
      end else begin
        src_a = sel_a[j*IW +: IW];
        src_b = sel_b[j*IW +: IW];
      end
      route_a_c[j*ADW +: ADW] = addr_a_in[src_a*ADW +: ADW];
      route_b_c[j*ADW +: ADW] = addr_b_in[src_b*ADW +: ADW];
    end
  end

  // Output slot and rotation counter next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    rot_cnt_d   = rot_cnt_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      addr_a_d    = route_a_c;
      addr_b_d    = route_b_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (rot_clr) begin
      rot_cnt_d = '0;
    end else if (accept_c && mode) begin
      rot_cnt_d = rot_cnt_q + IW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      rot_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      rot_cnt_q   <= rot_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign addr_a_out = addr_a_q;
  assign addr_b_out = addr_b_q;
  assign rot_cnt    = rot_cnt_q;

`ifdef XBAR_PERM_CHECK_EN
  logic dup_c;
  logic perm_err_q, perm_err_d;

  // Any repeated index in either select vector means it is not a permutation.
  always_comb begin
    dup_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = i + 1; k < N; k++) begin
        if (sel_a[i*IW +: IW] == sel_a[k*IW +: IW]) dup_c = 1'b1;
        if (sel_b[i*IW +: IW] == sel_b[k*IW +: IW]) dup_c = 1'b1;
      end
    end
  end

  // Sticky error: a new violation wins over a simultaneous clear.
  always_comb begin
    perm_err_d = perm_err_q;
    if (accept_c && !mode && dup_c) begin
      perm_err_d = 1'b1;
    end else if (err_clr) begin
      perm_err_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perm_err_q <= 1'b0;
    else     perm_err_q <= perm_err_d;
  end

  assign perm_err = perm_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign perm_err       = 1'b0;
`endif

endmodule

// File: tb/tb_addr_xbar_pipe.sv
// Scoreboard bench for addr_xbar_pipe (N=8, ADW=5).
module tb_addr_xbar_pipe;
  localparam int unsigned N   = 8;
  localparam int unsigned ADW = 5;
  localparam int unsigned IW  = 3;
`ifdef XBAR_PERM_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [N*ADW-1:0] addr_a_in, addr_b_in, addr_a_out, addr_b_out;
  logic [N*IW-1:0]  sel_a, sel_b;
  logic             mode, rot_clr, err_clr, out_valid, out_ready, perm_err;
  logic [IW-1:0]    rot_cnt;

  always #5 clk = ~clk;

  addr_xbar_pipe #(.N(N), .ADW(ADW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .addr_a_in(addr_a_in), .addr_b_in(addr_b_in), .sel_a(sel_a), .sel_b(sel_b),
    .mode(mode), .rot_clr(rot_clr), .err_clr(err_clr), .out_valid(out_valid),
    .out_ready(out_ready), .addr_a_out(addr_a_out), .addr_b_out(addr_b_out),
    .rot_cnt(rot_cnt), .perm_err(perm_err)
  );

  int checks = 0;
  int errors = 0;

  logic [N*ADW-1:0] q_a[$];
  logic [N*ADW-1:0] q_b[$];
  bit               m_valid;
  bit               m_err;
  logic [IW-1:0]    m_rot;
  logic [N*ADW-1:0] m_a, m_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*ADW-1:0] route(input logic [N*ADW-1:0] src,
                                             input logic [N*IW-1:0] sel,
                                             input bit md, input logic [IW-1:0] rot);
    logic [N*ADW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (md) s = (j + int'(rot)) % N;
      else    s = int'(sel[j*IW +: IW]);
      r[j*ADW +: ADW] = src[s*ADW +: ADW];
    end
    return r;
  endfunction

  function automatic bit has_dup(input logic [N*IW-1:0] sel);
    for (int i = 0; i < N; i++)
      for (int k = i + 1; k < N; k++)
        if (sel[i*IW +: IW] == sel[k*IW +: IW]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N*IW-1:0] sel_rev();
    logic [N*IW-1:0] s;
    for (int j = 0; j < N; j++) s[j*IW +: IW] = IW'(N - 1 - j);
    return s;
  endfunction

  function automatic logic [N*IW-1:0] sel_id();
    logic [N*IW-1:0] s;
    for (int j = 0; j < N; j++) s[j*IW +: IW] = IW'(j);
    return s;
  endfunction

  function automatic logic [N*ADW-1:0] lanes(input int base);
    logic [N*ADW-1:0] a;
    for (int k = 0; k < N; k++) a[k*ADW +: ADW] = ADW'(base + k);
    return a;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step(input string tag);
    bit acc;
    #1;
    check({tag, ":in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      q_a.push_back(route(addr_a_in, sel_a, mode, m_rot));
      q_b.push_back(route(addr_b_in, sel_b, mode, m_rot));
    end
    if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (PC && acc && !mode && (has_dup(sel_a) || has_dup(sel_b))) m_err = 1'b1;
    else if (PC && err_clr) m_err = 1'b0;
    if (rot_clr) m_rot = '0;
    else if (acc && mode) m_rot = m_rot + IW'(1);
    @(posedge clk);
    #1;
    if (acc) begin
      if (q_a.size() == 0 || q_b.size() == 0) begin
        check({tag, ":queue_empty"}, 64'(1), 64'(0));
      end else begin
        m_a = q_a.pop_front();
        m_b = q_b.pop_front();
      end
    end
    check({tag, ":out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ":addr_a"}, 64'(addr_a_out), 64'(m_a));
    check({tag, ":addr_b"}, 64'(addr_b_out), 64'(m_b));
    check({tag, ":rot_cnt"}, 64'(rot_cnt), 64'(m_rot));
    check({tag, ":perm_err"}, 64'(perm_err), 64'(m_err));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_err = 1'b0; m_rot = '0; m_a = '0; m_b = '0;
    q_a.delete(); q_b.delete();
  endtask

  logic [N*IW-1:0] bad_sel;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    rot_clr = 1'b0; err_clr = 1'b0;
    addr_a_in = '0; addr_b_in = '0; sel_a = '0; sel_b = '0;
    model_reset();
    #12;
    check("rst:out_valid", 64'(out_valid), 64'(0));
    check("rst:addr_a", 64'(addr_a_out), 64'(0));
    check("rst:addr_b", 64'(addr_b_out), 64'(0));
    check("rst:rot_cnt", 64'(rot_cnt), 64'(0));
    check("rst:perm_err", 64'(perm_err), 64'(0));
    check("rst:in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Explicit reversal routing.
    addr_a_in = lanes(8); addr_b_in = lanes(20);
    sel_a = sel_rev(); sel_b = sel_id();
    in_valid = 1'b1; out_ready = 1'b1;
    step("rev");
    check("rev:bank0", 64'(addr_a_out[0 +: ADW]), 64'(15));
    check("rev:bank7", 64'(addr_a_out[7*ADW +: ADW]), 64'(8));
    check("rev:b_bank3", 64'(addr_b_out[3*ADW +: ADW]), 64'(23));

    // Rotate mode, 10 back-to-back beats.
    mode = 1'b1; addr_a_in = lanes(0); addr_b_in = lanes(16);
    for (int t = 0; t < 10; t++) begin
      step("rot");
      check("rot:bank0", 64'(addr_a_out[0 +: ADW]), 64'(t % 8));
      check("rot:cnt", 64'(rot_cnt), 64'((t + 1) % 8));
    end

    // Back-pressure hold.
    in_valid = 1'b0; step("drain");
    mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    addr_a_in = lanes(3); sel_a = sel_rev();
    step("hold_in");
    addr_a_in = lanes(11);
    for (int t = 0; t < 3; t++) begin
      step("hold");
      check("hold:in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    step("release");

    // Sticky permutation error.
    bad_sel = sel_id();
    bad_sel[2*IW +: IW] = IW'(3);
    bad_sel[5*IW +: IW] = IW'(3);
    sel_a = sel_rev(); sel_b = bad_sel; addr_b_in = lanes(9);
    step("dup");
    check("dup:perm_err", 64'(perm_err), 64'(PC));
    sel_b = sel_id();
    for (int t = 0; t < 3; t++) step("good");
    check("good:perm_err", 64'(perm_err), 64'(PC));
    sel_b = bad_sel; err_clr = 1'b1;
    step("clr_dup");
    check("clr_dup:perm_err", 64'(perm_err), 64'(PC));
    in_valid = 1'b0;
    step("clr");
    check("clr:perm_err", 64'(perm_err), 64'(0));
    err_clr = 1'b0;

    // rot_clr racing an accepted rotate beat at offset 5.
    rot_clr = 1'b1; step("rclr0"); rot_clr = 1'b0;
    mode = 1'b1; in_valid = 1'b1; addr_a_in = lanes(0);
    for (int t = 0; t < 5; t++) step("rot5");
    check("rot5:cnt", 64'(rot_cnt), 64'(5));
    rot_clr = 1'b1;
    step("rclr");
    check("rclr:bank0", 64'(addr_a_out[0 +: ADW]), 64'(5));
    check("rclr:cnt", 64'(rot_cnt), 64'(0));
    rot_clr = 1'b0;

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      rot_clr   = ($urandom_range(0, 9) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      addr_a_in = 40'({$urandom(), $urandom()});
      addr_b_in = 40'({$urandom(), $urandom()});
      sel_a     = ($urandom_range(0, 1) == 0) ? sel_rev() : 24'($urandom);
      sel_b     = ($urandom_range(0, 1) == 0) ? sel_id() : 24'($urandom);
      step("rand");
    end
    rot_clr = 1'b0; err_clr = 1'b0;

    // Async reset while a beat is held.
    mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1; addr_a_in = lanes(1);
    step("pre_rst");
    mode = 1'b0; sel_b = bad_sel; out_ready = 1'b0;
    in_valid = 1'b0; step("pre_rst2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst:out_valid", 64'(out_valid), 64'(0));
    check("arst:addr_a", 64'(addr_a_out), 64'(0));
    check("arst:addr_b", 64'(addr_b_out), 64'(0));
    check("arst:rot_cnt", 64'(rot_cnt), 64'(0));
    check("arst:perm_err", 64'(perm_err), 64'(0));
    check("arst:in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; sel_a = sel_rev(); sel_b = sel_id();
    addr_a_in = lanes(2); addr_b_in = lanes(4);
    step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_xbar_pipe.md
Name: addr_xbar_pipe

Overview:
- Parametrised, registered successor of the 8x8 address crossbar.
- Routes N address lanes to N BRAM banks for two port sets, A and B, using per-bank source selects.
- Adds a rotate mode for the NTT bank-rotation schedule, valid/ready flow control with a one-stage output register, and sticky permutation-error detection.
- Sits between the butterfly address generators and the bank BRAM address pins.

Parameters:
- N, 8: lane/bank count. Power of two, N >= 2.
- ADW, 5: address width per lane.
- IW, $clog2(N): select width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- addr_a_in  in  N*ADW  port-A source addresses, lane k at [k*ADW +: ADW]
- addr_b_in  in  N*ADW  port-B source addresses, same packing
- sel_a  in  N*IW  port-A source select for bank j at [j*IW +: IW]
- sel_b  in  N*IW  port-B source select for bank j, same packing
- mode  in  1  0 = explicit selects, 1 = rotate
- rot_clr  in  1  synchronous clear of rotation counter
- err_clr  in  1  synchronous clear of perm_err
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- addr_a_out  out  N*ADW  port-A bank addresses, bank j at [j*ADW +: ADW]
- addr_b_out  out  N*ADW  port-B bank addresses
- rot_cnt  out  IW  current rotation offset
- perm_err  out  1  sticky: non-permutation select seen

Behaviour:
- Reset (async, rst=1): out_valid=0, addr_a_out=0, addr_b_out=0, rot_cnt=0, perm_err=0.
- in_ready = !out_valid || out_ready (combinational); equals 1 immediately after reset.
- Accept: a beat is accepted when in_valid && in_ready.
- Routing, mode=0: bank j gets addr_a_in lane sel_a[j] and addr_b_in lane sel_b[j].
- Routing, mode=1: A and B both use source lane (j + rot_cnt) mod N; sel_a/sel_b are ignored.
- Latency: routed addresses are registered on accept and appear with out_valid=1 the next cycle (1 cycle).
- Output hold: while out_valid=1 && out_ready=0, outputs and out_valid are held stable and in_ready=0.
- Output clear: if out_ready=1 and no beat is accepted, out_valid drops to 0; data registers keep their last value.
- Simultaneous out_ready and in_valid with out_valid=1: the new beat replaces the old one in the same cycle, giving full throughput of 1 beat/cycle.
- rot_cnt:
  - increments by 1 mod N on each accepted beat with mode=1, wrapping N-1 -> 0;
  - the accepted beat routes with the pre-increment value;
  - rot_clr=1 forces 0 next cycle and has priority over increment;
  - unchanged on mode=0 beats.
- perm_err:
  - set on an accepted mode=0 beat where sel_a or sel_b contains a duplicate index (i.e. is not a permutation of 0..N-1);
  - cleared by err_clr; if set and err_clr happen in the same cycle, set wins;
  - the beat is still routed as commanded; no blocking.
- Reset mid-beat: any held output beat is discarded, out_valid=0, and the pending transfer is lost.
- Non-accepted cycles: no state change other than rot_clr/err_clr.

Optional Feature:
- Macro: XBAR_PERM_CHECK_EN.
- Defined: duplicate-select checker as described above; perm_err functional.
- Undefined: checker not built, perm_err tied 0, err_clr ignored; all other behaviour identical.

Test Plan:
- N=8, ADW=5, reset. Then addr_a_in lane k = k+8, sel_a[j]=7-j, mode=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, addr_a_out bank0=15 and bank7=8; perm_err=0.
- mode=1, addr_a_in lane k = k, 10 back-to-back beats from rot_cnt=0 -> beat t bank0 = t mod 8; rot_cnt goes 7 -> 0 -> 1; one beat per cycle.
- Hold out_ready=0 for 3 cycles after a beat -> out_valid=1, outputs stable, in_ready=0. Raise out_ready -> in_ready=1 that same cycle.
- mode=0, sel_b with bank2 = bank5 = 3 -> perm_err=1 next cycle and stays 1 over following good beats. Assert err_clr and a duplicate beat together -> perm_err stays 1; err_clr alone -> perm_err=0.
- rot_cnt=5, rot_clr=1 together with an accepted mode=1 beat -> beat routed with offset 5; rot_cnt=0 next cycle.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid, addresses, rot_cnt and perm_err all 0 asynchronously; in_ready=1.
